// File: rtl/clk_meas_pkg.sv
// Shared types and default sizing for the divided-clock period monitor.
package clk_meas_pkg;

  localparam int unsigned CNT_W_DEF    = 8;
  localparam int unsigned LOCK_CNT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } meas_state_e;

endpackage

// File: rtl/edge_detect.sv
// Registers the measured level once and flags its rising/falling transitions.
module edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic s_q;
  logic s_prev_q;

  // Both stages reset high so a level already high at reset release is not a rise
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s_q      <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      s_q      <= d_i;
      s_prev_q <= s_q;
    end
  end

  assign rise_o = s_q & ~s_prev_q;
  assign fall_o = ~s_q & s_prev_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures high/low phase lengths of a divided clock and reports lock when
// consecutive periods repeat; a phase too long for the counters sets sticky overflow.
module clk_div_monitor
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             locked,
  output logic             overflow
);

  localparam int unsigned          MATCH_W  = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [MATCH_W-1:0]   LOCK_VAL = MATCH_W'(LOCK_CNT);

  meas_state_e        state_q, state_d;
  logic [CNT_W-1:0]   hc_q, hc_d, lc_q, lc_d;
  logic [CNT_W-1:0]   high_cnt_q, high_cnt_d, low_cnt_q, low_cnt_d;
  logic [CNT_W:0]     period_q, period_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               meas_valid_q, meas_valid_d;
  logic               locked_q, locked_d;
  logic               overflow_q, overflow_d;
  logic               rise_s, fall_s;

  edge_detect u_edge (
    .clk_in (clk_in),
    .rst    (rst),
    .d_i    (div_in),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A saturated counter that must count again aborts the measurement back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) state_d = ST_HIGH;
        else        state_d = ST_IDLE;
      end
      ST_HIGH: begin
        if (fall_s)                state_d = ST_LOW;
        else if (hc_q == CNT_MAX)  state_d = ST_IDLE;
        else                       state_d = ST_HIGH;
      end
      ST_LOW: begin
        if (rise_s)                state_d = ST_HIGH;
        else if (lc_q == CNT_MAX)  state_d = ST_IDLE;
        else                       state_d = ST_LOW;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hc_d         = hc_q;
    lc_d         = lc_q;
    match_d      = match_q;
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    overflow_d   = overflow_q;
    case (state_q)
      ST_IDLE: begin
        lc_d = {CNT_W{1'b0}};
        if (rise_s) hc_d = CNT_W'(1'b1);
        else        hc_d = {CNT_W{1'b0}};
      end
      ST_HIGH: begin
        if (fall_s) begin
          lc_d = CNT_W'(1'b1);
        end else if (hc_q == CNT_MAX) begin
          hc_d       = {CNT_W{1'b0}};
          lc_d       = {CNT_W{1'b0}};
          match_d    = {MATCH_W{1'b0}};
          locked_d   = 1'b0;
          overflow_d = 1'b1;
        end else begin
          hc_d = hc_q + CNT_W'(1'b1);
        end
      end
      ST_LOW: begin
        if (rise_s) begin
          high_cnt_d   = hc_q;
          low_cnt_d    = lc_q;
          period_d     = {1'b0, hc_q} + {1'b0, lc_q};
          meas_valid_d = 1'b1;
          // Compare against the pair still held on the outputs, i.e. the previous publish
          if ((hc_q == high_cnt_q) && (lc_q == low_cnt_q)) begin
            if (match_q >= LOCK_VAL) match_d = LOCK_VAL;
            else                     match_d = match_q + MATCH_W'(1'b1);
          end else begin
            match_d = MATCH_W'(1'b1);
          end
          locked_d = (match_d >= LOCK_VAL);
          hc_d     = CNT_W'(1'b1);
          lc_d     = {CNT_W{1'b0}};
        end else if (lc_q == CNT_MAX) begin
          hc_d       = {CNT_W{1'b0}};
          lc_d       = {CNT_W{1'b0}};
          match_d    = {MATCH_W{1'b0}};
          locked_d   = 1'b0;
          overflow_d = 1'b1;
        end else begin
          lc_d = lc_q + CNT_W'(1'b1);
        end
      end
      default: begin
        hc_d = {CNT_W{1'b0}};
        lc_d = {CNT_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      hc_q         <= {CNT_W{1'b0}};
      lc_q         <= {CNT_W{1'b0}};
      match_q      <= {MATCH_W{1'b0}};
      high_cnt_q   <= {CNT_W{1'b0}};
      low_cnt_q    <= {CNT_W{1'b0}};
      period_q     <= {(CNT_W+1){1'b0}};
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      hc_q         <= hc_d;
      lc_q         <= lc_d;
      match_q      <= match_d;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      overflow_q   <= overflow_d;
    end
  end

  assign high_cnt   = high_cnt_q;
  assign low_cnt    = low_cnt_q;
  assign period     = period_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized and directed bench for clk_div_monitor, checked against a run-length reference model.
module tb_clk_div_monitor;

  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic             div_in = 1'b0;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W:0]   period;
  logic             meas_valid;
  logic             locked;
  logic             overflow;

  clk_div_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .div_in     (div_in),
    .high_cnt   (high_cnt),
    .low_cnt    (low_cnt),
    .period     (period),
    .meas_valid (meas_valid),
    .locked     (locked),
    .overflow   (overflow)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int h;
    int l;
    int p;
    bit lk;
  } meas_t;

  meas_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  // Reference model: tracks runs of equal levels rather than any FSM encoding
  bit m_lvl;
  bit m_counting;
  bit m_locked;
  bit m_ovf;
  int m_h;
  int m_run;
  int m_pub_h;
  int m_pub_l;
  int hist_h[$];
  int hist_l[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl      = 1'b1;
    m_counting = 1'b0;
    m_locked   = 1'b0;
    m_ovf      = 1'b0;
    m_h        = 0;
    m_run      = 0;
    m_pub_h    = 0;
    m_pub_l    = 0;
    hist_h.delete();
    hist_l.delete();
    exp_q.delete();
  endtask

  // Locked means the last LOCK_CNT publishes since reset/overflow are all the same pair
  task automatic model_publish(input int h, input int l);
    meas_t e;
    bit    same;
    hist_h.push_back(h);
    hist_l.push_back(l);
    if (hist_h.size() > LOCK_CNT) begin
      void'(hist_h.pop_front());
      void'(hist_l.pop_front());
    end
    same = (hist_h.size() == LOCK_CNT);
    foreach (hist_h[i]) begin
      if (hist_h[i] != h || hist_l[i] != l) same = 1'b0;
    end
    m_locked = same;
    m_pub_h  = h;
    m_pub_l  = l;
    e.h  = h;
    e.l  = l;
    e.p  = h + l;
    e.lk = same;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input logic v);
    if (v && !m_lvl) begin
      if (m_counting && m_h > 0) model_publish(m_h, m_run);
      m_counting = 1'b1;
      m_h        = 0;
      m_run      = 1;
    end else if (!v && m_lvl) begin
      if (m_counting) m_h = m_run;
      m_run = 1;
    end else begin
      m_run++;
    end
    m_lvl = v;
    if (m_counting && m_run > MAXC) begin
      m_counting = 1'b0;
      m_h        = 0;
      m_locked   = 1'b0;
      m_ovf      = 1'b1;
      hist_h.delete();
      hist_l.delete();
    end
  endtask

  task automatic cycle(input logic v);
    @(negedge clk_in);
    rst    = 1'b0;
    div_in = v;
    model_step(v);
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) cycle(v);
  endtask

  task automatic periods(input int h, input int l, input int reps);
    repeat (reps) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic do_reset(input int n, input logic v);
    repeat (n) begin
      @(negedge clk_in);
      rst    = 1'b1;
      div_in = v;
      model_reset();
    end
  endtask

  // Monitor: outputs after edge k reflect the model as it stood at edge k-1
  initial begin : monitor
    int    ph, pl, pk, po;
    bit    prev_mv;
    meas_t e;
    ph = 0; pl = 0; pk = 0; po = 0; prev_mv = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (rst) begin
        check("reset_high_cnt", high_cnt, 0);
        check("reset_low_cnt", low_cnt, 0);
        check("reset_period", period, 0);
        check("reset_meas_valid", meas_valid, 0);
        check("reset_locked", locked, 0);
        check("reset_overflow", overflow, 0);
      end else begin
        check("high_cnt", high_cnt, ph);
        check("low_cnt", low_cnt, pl);
        check("period", period, ph + pl);
        check("locked", locked, pk);
        check("overflow", overflow, po);
        if (meas_valid) begin
          check("meas_valid_back_to_back", prev_mv, 0);
          check("meas_valid_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pub_high_cnt", high_cnt, e.h);
            check("pub_low_cnt", low_cnt, e.l);
            check("pub_period", period, e.p);
            check("pub_locked", locked, e.lk);
          end
        end
      end
      prev_mv = meas_valid;
      ph = m_pub_h;
      pl = m_pub_l;
      pk = m_locked;
      po = m_ovf;
    end
  end

  initial begin : stimulus
    model_reset();
    do_reset(2, 1'b0);
    // Nominal divide-by-5: 2 high / 3 low, lock on the 4th publish
    drive(1'b0, 1);
    periods(2, 3, 6);
    // One 3/3 period breaks lock, four identical ones restore it
    periods(3, 3, 5);
    // Reset mid-LOW while locked
    periods(2, 3, 5);
    drive(1'b1, 2);
    drive(1'b0, 1);
    do_reset(1, 1'b0);
    drive(1'b0, 2);
    periods(2, 3, 3);
    // Fastest legal period: toggle every cycle
    periods(1, 1, 10);
    // Level held high through reset release is not a rise
    drive(1'b1, 1);
    do_reset(2, 1'b1);
    drive(1'b1, 5);
    drive(1'b0, 3);
    periods(2, 3, 3);
    // High phase overflow, recovery while overflow stays sticky, then low phase overflow
    drive(1'b0, 2);
    drive(1'b1, 300);
    drive(1'b0, 4);
    periods(2, 3, 3);
    drive(1'b1, 2);
    drive(1'b0, 258);
    periods(3, 2, 3);
    do_reset(1, 1'b0);
    drive(1'b0, 2);
    // Random periods with repeats and occasional resets
    for (int i = 0; i < 40; i++) begin
      int h, l, reps;
      h    = $urandom_range(1, 5);
      l    = $urandom_range(1, 5);
      reps = $urandom_range(1, 6);
      periods(h, l, reps);
      if ($urandom_range(0, 9) == 0) begin
        drive(1'b1, $urandom_range(0, 2));
        do_reset(1, 1'(($urandom_range(0, 1))));
      end
    end
    drive(1'b1, 1);
    drive(1'b0, 4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
